// File: rtl/lfsr17_checker.sv
// Lock detector / bit-error monitor for a serial 17-bit LFSR stream (taps 17,14).
// Define LFSR17_CHECKER_STATS_EN to build the err_count/bit_count statistics registers.
//
// state  | meaning
// HUNT   | shifting received bits into r until 17 are collected
// VERIFY | r seeded from the line; counting consecutive correct predictions
// LOCKED | r free-runs on its own predictions; mismatches counted per window
module lfsr17_checker #(
    parameter int unsigned VERIFY_LEN = 8,
    parameter int unsigned ERR_THRESH = 4,
    parameter int unsigned WINDOW     = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        bit_in,
    input  logic        bit_valid,
    input  logic        clear,
    output logic        locked,
    output logic        err_pulse,
    output logic        lock_lost,
    output logic [15:0] err_count,
    output logic [31:0] bit_count
);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic [7:0]  VERIFY_LEN_W = 8'(VERIFY_LEN);
    localparam logic [7:0]  ERR_THRESH_W = 8'(ERR_THRESH);
    localparam logic [15:0] WINDOW_W     = 16'(WINDOW);
    localparam logic [4:0]  FILL_LAST    = 5'd16;

    state_t      state, state_nxt;
    logic [16:0] r, r_nxt;
    logic [4:0]  fill_cnt, fill_cnt_nxt;
    logic [7:0]  match_cnt, match_cnt_nxt;
    logic [15:0] win_bits, win_bits_nxt;
    logic [7:0]  win_err, win_err_nxt;
    logic        err_pulse_nxt, lock_lost_nxt;

    logic        pred;
    logic        mismatch;
    logic [16:0] r_line;
    logic [7:0]  match_inc;
    logic [7:0]  win_err_inc;
    logic [15:0] win_bits_inc;

    assign pred         = r[16] ^ r[13];
    assign mismatch     = bit_in ^ pred;
    assign r_line       = {r[15:0], bit_in};
    assign match_inc    = match_cnt + 8'd1;
    assign win_err_inc  = win_err + {7'd0, mismatch};
    assign win_bits_inc = win_bits + 16'd1;

    always_comb begin
        state_nxt     = state;
        r_nxt         = r;
        fill_cnt_nxt  = fill_cnt;
        match_cnt_nxt = match_cnt;
        win_bits_nxt  = win_bits;
        win_err_nxt   = win_err;
        err_pulse_nxt = 1'b0;
        lock_lost_nxt = 1'b0;

        case (state)
            HUNT: begin
                if (bit_valid) begin
                    r_nxt = r_line;
                    if (fill_cnt == FILL_LAST) begin
                        // an all-zero fill is the LFSR lock-up state; refill from scratch
                        fill_cnt_nxt = 5'd0;
                        if (r_line != 17'd0) begin
                            state_nxt = VERIFY;
                        end
                    end else begin
                        fill_cnt_nxt = fill_cnt + 5'd1;
                    end
                end
            end

            VERIFY: begin
                if (bit_valid) begin
                    r_nxt = r_line;
                    if (!mismatch) begin
                        if (match_inc == VERIFY_LEN_W) begin
                            state_nxt     = LOCKED;
                            match_cnt_nxt = 8'd0;
                            win_bits_nxt  = 16'd0;
                            win_err_nxt   = 8'd0;
                        end else begin
                            match_cnt_nxt = match_inc;
                        end
                    end else begin
                        state_nxt     = HUNT;
                        fill_cnt_nxt  = 5'd0;
                        match_cnt_nxt = 8'd0;
                    end
                end
            end

            LOCKED: begin
                if (bit_valid) begin
                    // free-run on the prediction so a line error never corrupts r
                    r_nxt         = {r[15:0], pred};
                    err_pulse_nxt = mismatch;
                    if (win_err_inc == ERR_THRESH_W) begin
                        state_nxt     = HUNT;
                        lock_lost_nxt = 1'b1;
                        fill_cnt_nxt  = 5'd0;
                        match_cnt_nxt = 8'd0;
                        win_bits_nxt  = 16'd0;
                        win_err_nxt   = 8'd0;
                    end else if (win_bits_inc == WINDOW_W) begin
                        win_bits_nxt = 16'd0;
                        win_err_nxt  = 8'd0;
                    end else begin
                        win_bits_nxt = win_bits_inc;
                        win_err_nxt  = win_err_inc;
                    end
                end
            end

            default: begin
                state_nxt = HUNT;
            end
        endcase

        if (clear) begin
            state_nxt     = HUNT;
            r_nxt         = 17'd0;
            fill_cnt_nxt  = 5'd0;
            match_cnt_nxt = 8'd0;
            win_bits_nxt  = 16'd0;
            win_err_nxt   = 8'd0;
            err_pulse_nxt = 1'b0;
            lock_lost_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= HUNT;
            r         <= 17'd0;
            fill_cnt  <= 5'd0;
            match_cnt <= 8'd0;
            win_bits  <= 16'd0;
            win_err   <= 8'd0;
            err_pulse <= 1'b0;
            lock_lost <= 1'b0;
        end else begin
            state     <= state_nxt;
            r         <= r_nxt;
            fill_cnt  <= fill_cnt_nxt;
            match_cnt <= match_cnt_nxt;
            win_bits  <= win_bits_nxt;
            win_err   <= win_err_nxt;
            err_pulse <= err_pulse_nxt;
            lock_lost <= lock_lost_nxt;
        end
    end

    assign locked = (state == LOCKED);

`ifdef LFSR17_CHECKER_STATS_EN
    logic        count_bit;
    logic        count_err;
    logic [15:0] err_cnt_q;
    logic [31:0] bit_cnt_q;

    assign count_bit = bit_valid && (state == LOCKED);
    assign count_err = count_bit && mismatch;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_cnt_q <= 16'd0;
            bit_cnt_q <= 32'd0;
        end else if (clear) begin
            err_cnt_q <= 16'd0;
            bit_cnt_q <= 32'd0;
        end else begin
            if (count_err && (err_cnt_q != 16'hFFFF)) begin
                err_cnt_q <= err_cnt_q + 16'd1;
            end
            if (count_bit && (bit_cnt_q != 32'hFFFF_FFFF)) begin
                bit_cnt_q <= bit_cnt_q + 32'd1;
            end
        end
    end

    assign err_count = err_cnt_q;
    assign bit_count = bit_cnt_q;
`else
    assign err_count = 16'd0;
    assign bit_count = 32'd0;
`endif

endmodule

// File: tb/tb_lfsr17_checker.sv
// Scoreboard bench for lfsr17_checker: a reference LFSR generator drives the line and
// a spec-level lock tracker queues the expected outputs for each clock.
module tb_lfsr17_checker;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        bit_in = 1'b0;
    logic        bit_valid = 1'b0;
    logic        clear = 1'b0;
    logic        locked;
    logic        err_pulse;
    logic        lock_lost;
    logic [15:0] err_count;
    logic [31:0] bit_count;

    lfsr17_checker dut (
        .clk       (clk),
        .rst       (rst),
        .bit_in    (bit_in),
        .bit_valid (bit_valid),
        .clear     (clear),
        .locked    (locked),
        .err_pulse (err_pulse),
        .lock_lost (lock_lost),
        .err_count (err_count),
        .bit_count (bit_count)
    );

    always #5 clk = ~clk;

`ifdef LFSR17_CHECKER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    typedef struct {
        string       tag;
        logic        locked;
        logic        err_pulse;
        logic        lock_lost;
        logic [15:0] err_count;
        logic [31:0] bit_count;
    } exp_t;

    exp_t        exp_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;

    logic [16:0] gen;
    bit          zero_mode;
    bit          trk_locked;
    int          acq_bits;
    int          win_pos;
    int          win_errs;
    int unsigned err_tot;
    int unsigned bit_tot;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic trk_clear();
        trk_locked = 1'b0;
        acq_bits   = 0;
        win_pos    = 0;
        win_errs   = 0;
        err_tot    = 0;
        bit_tot    = 0;
    endtask

    // one clock: drive at negedge, queue the expectation, compare 1 ns after the edge
    task automatic step(input bit v, input bit flip, input bit clr, input string tag);
        exp_t e;
        logic b;
        b = 1'b0;
        if (v) begin
            b   = gen[16] ^ gen[13];
            gen = {gen[15:0], b};
            if (zero_mode) b = 1'b0;
            b = b ^ flip;
        end
        bit_in    = b;
        bit_valid = v;
        clear     = clr;

        e.tag       = tag;
        e.err_pulse = 1'b0;
        e.lock_lost = 1'b0;
        if (clr) begin
            trk_clear();
        end else if (v) begin
            if (trk_locked) begin
                if (bit_tot != 32'hFFFF_FFFF) bit_tot++;
                if (flip) begin
                    e.err_pulse = 1'b1;
                    if (err_tot < 32'hFFFF) err_tot++;
                    win_errs++;
                end
                if (win_errs == 4) begin
                    trk_locked  = 1'b0;
                    acq_bits    = 0;
                    win_pos     = 0;
                    win_errs    = 0;
                    e.lock_lost = 1'b1;
                end else begin
                    win_pos++;
                    if (win_pos == 64) begin
                        win_pos  = 0;
                        win_errs = 0;
                    end
                end
            end else if (!zero_mode) begin
                acq_bits++;
                if (acq_bits == 25) begin
                    trk_locked = 1'b1;
                    win_pos    = 0;
                    win_errs   = 0;
                end
            end
        end
        e.locked    = trk_locked;
        e.err_count = STATS ? 16'(err_tot) : 16'd0;
        e.bit_count = STATS ? bit_tot : 32'd0;
        exp_q.push_back(e);

        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk({e.tag, "/locked"},    32'(locked),    32'(e.locked));
        chk({e.tag, "/err_pulse"}, 32'(err_pulse), 32'(e.err_pulse));
        chk({e.tag, "/lock_lost"}, 32'(lock_lost), 32'(e.lock_lost));
        chk({e.tag, "/err_count"}, 32'(err_count), 32'(e.err_count));
        chk({e.tag, "/bit_count"}, bit_count,      e.bit_count);
        @(negedge clk);
        bit_valid = 1'b0;
        clear     = 1'b0;
    endtask

    // n valid bits; f0..f3 are 1-based indices of bits to invert (0 = unused)
    task automatic run(input int n, input int f0, input int f1, input int f2, input int f3,
                       input bit gaps, input string tag);
        for (int i = 1; i <= n; i++) begin
            if (gaps && ($urandom_range(0, 1) == 1)) begin
                step(1'b0, 1'b0, 1'b0, {tag, "_gap"});
            end
            step(1'b1, (i == f0) || (i == f1) || (i == f2) || (i == f3), 1'b0, tag);
        end
    endtask

    task automatic do_reset(input string tag);
        #2;
        rst = 1'b0;
        #1;
        chk({tag, "/locked"},    32'(locked),    32'd0);
        chk({tag, "/err_pulse"}, 32'(err_pulse), 32'd0);
        chk({tag, "/lock_lost"}, 32'(lock_lost), 32'd0);
        chk({tag, "/err_count"}, 32'(err_count), 32'd0);
        chk({tag, "/bit_count"}, bit_count,      32'd0);
        trk_clear();
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        gen       = 17'h00001;
        zero_mode = 1'b0;
        trk_clear();

        do_reset("reset");

        run(25, 0, 0, 0, 0, 1'b0, "acquire");
        run(30, 5, 0, 0, 0, 1'b0, "single_err");
        run(34, 10, 20, 0, 0, 1'b0, "win1_3err");
        run(64, 1, 30, 64, 0, 1'b0, "win2_3err");
        run(64, 5, 10, 15, 20, 1'b0, "loss_relock");
        run(45, 0, 0, 0, 0, 1'b0, "win_align");
        run(64, 61, 62, 63, 64, 1'b0, "loss_at_wrap");
        run(30, 0, 0, 0, 0, 1'b0, "relock2");

        step(1'b1, 1'b0, 1'b1, "clear_locked");
        run(40, 0, 0, 0, 0, 1'b1, "gaps");

        step(1'b1, 1'b0, 1'b1, "clear2");
        run(20, 0, 0, 0, 0, 1'b0, "pre_rst");
        do_reset("rst_verify");
        run(30, 0, 0, 0, 0, 1'b0, "post_rst");

        step(1'b0, 1'b0, 1'b1, "clear3");
        zero_mode = 1'b1;
        run(200, 0, 0, 0, 0, 1'b0, "zeros");
        zero_mode = 1'b0;
        step(1'b0, 1'b0, 1'b1, "clear4");
        run(30, 0, 0, 0, 0, 1'b0, "final_lock");

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
